// File: rtl/seq_pkg.sv
// Shared types and constants for the serial pattern generator.
// Optional inter-repetition gap state is enabled by SEQ_GENERATOR_GAP_EN.
package seq_pkg;

    localparam int SEQ_WIDTH_DEFAULT = 4;
    localparam int SEQ_CNT_W_DEFAULT = 8;

    localparam logic [3:0] SEQ_PATTERN_1001 = 4'b1001;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } seq_state_t;

endpackage

// File: rtl/seq_piso.sv
// Parallel-in serial-out shift register; load has priority over shift,
// and bits leave from the MSB end.
module seq_piso
    import seq_pkg::*;
#(
    parameter int WIDTH = SEQ_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             msb
);

    logic [WIDTH-1:0] sreg;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sreg <= '0;
        end else if (load) begin
            sreg <= din;
        end else if (shift) begin
            sreg <= {sreg[WIDTH-2:0], 1'b0};
        end
    end

    assign msb = sreg[WIDTH-1];

endmodule

// File: rtl/seq_generator.sv
// Serial pattern transmitter: sends a latched WIDTH-bit pattern MSB-first,
// repeat_cnt times. Define SEQ_GENERATOR_GAP_EN for one idle cycle between repetitions.
module seq_generator
    import seq_pkg::*;
#(
    parameter int WIDTH = SEQ_WIDTH_DEFAULT,
    parameter int CNT_W = SEQ_CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] pattern,
    input  logic [CNT_W-1:0] repeat_cnt,
    output logic             out,
    output logic             out_valid,
    output logic             busy,
    output logic             done
);

    localparam int BIT_W = $clog2(WIDTH);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);

    seq_state_t       state_q, state_d;
    logic [WIDTH-1:0] pat_q;
    logic [BIT_W-1:0] bit_cnt_q;
    logic [CNT_W-1:0] rep_cnt_q;
    logic             done_q, done_d;

    logic             accept;
    logic             bit_load, bit_dec, rep_dec;
    logic             piso_load, piso_shift, piso_msb;
    logic [WIDTH-1:0] piso_din;

    seq_piso #(.WIDTH(WIDTH)) u_piso (
        .clk    (clk),
        .resetn (resetn),
        .load   (piso_load),
        .shift  (piso_shift),
        .din    (piso_din),
        .msb    (piso_msb)
    );

    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        bit_load   = 1'b0;
        bit_dec    = 1'b0;
        rep_dec    = 1'b0;
        piso_load  = 1'b0;
        piso_shift = 1'b0;
        piso_din   = pat_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_valid) begin
                    accept    = 1'b1;
                    bit_load  = 1'b1;
                    piso_load = 1'b1;
                    piso_din  = pattern;
                    if (repeat_cnt == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                if (bit_cnt_q == '0) begin
                    rep_dec = 1'b1;
                    if (rep_cnt_q == CNT_W'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        // Reload from the latched copy so inputs changed mid-transfer have no effect
                        piso_load = 1'b1;
                        bit_load  = 1'b1;
`ifdef SEQ_GENERATOR_GAP_EN
                        state_d   = GAP;
`endif
                    end
                end else begin
                    piso_shift = 1'b1;
                    bit_dec    = 1'b1;
                end
            end
`ifdef SEQ_GENERATOR_GAP_EN
            GAP: begin
                state_d = SHIFT;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            pat_q     <= '0;
            bit_cnt_q <= '0;
            rep_cnt_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            if (accept) begin
                pat_q     <= pattern;
                rep_cnt_q <= repeat_cnt;
            end else if (rep_dec && rep_cnt_q != '0) begin
                rep_cnt_q <= rep_cnt_q - CNT_W'(1);
            end
            if (bit_load) begin
                bit_cnt_q <= LAST_BIT;
            end else if (bit_dec) begin
                bit_cnt_q <= bit_cnt_q - BIT_W'(1);
            end
        end
    end

    assign start_ready = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign out_valid   = (state_q == SHIFT);
    assign out         = out_valid & piso_msb;
    assign done        = done_q;

endmodule

// File: tb/tb_seq_generator.sv
// Directed bench for seq_generator: table of patterns/repeat counts with
// hand-written serial streams, plus back-to-back, busy-ignore and mid-reset sequences.
module tb_seq_generator;
    import seq_pkg::*;

`ifdef SEQ_GENERATOR_GAP_EN
    localparam bit GAP_EN = 1'b1;
`else
    localparam bit GAP_EN = 1'b0;
`endif

    logic       clk;
    logic       resetn;
    logic       start_valid;
    logic       start_ready;
    logic [3:0] pattern;
    logic [7:0] repeat_cnt;
    logic       out;
    logic       out_valid;
    logic       busy;
    logic       done;

    int passCount  = 0;
    int checkCount = 0;

    // Expected per-cycle outputs packed as {out, out_valid, busy, done, start_ready}
    logic [4:0] expQ[$];

    typedef struct {
        logic [3:0]  pattern;
        logic [7:0]  rpt;
        logic [15:0] bits;
        int          len;
    } vec_t;

    vec_t vecs[6];

    seq_generator #(.WIDTH(4), .CNT_W(8)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .pattern     (pattern),
        .repeat_cnt  (repeat_cnt),
        .out         (out),
        .out_valid   (out_valid),
        .busy        (busy),
        .done        (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [4:0] expected);
        logic [4:0] actual;
        actual = {out, out_valid, busy, done, start_ready};
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %b, expected %b (out,valid,busy,done,ready) at %0t",
                     name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] pat, input logic [7:0] rpt, input bit keep);
        @(negedge clk);
        start_valid = 1'b1;
        pattern     = pat;
        repeat_cnt  = rpt;
        @(posedge clk);
        #1;
        if (!keep) start_valid = 1'b0;
    endtask

    task automatic buildExpected(input logic [15:0] bits, input int len, input int reps);
        if (reps == 0) begin
            expQ.push_back(5'b00011);
        end else begin
            for (int i = 0; i < len; i++) begin
                expQ.push_back({bits[len-1-i], 4'b1100});
                if (GAP_EN && (i % 4 == 3) && (i != len - 1)) expQ.push_back(5'b00100);
            end
            expQ.push_back(5'b00011);
        end
    endtask

    task automatic playExpected(input string name);
        logic [4:0] e;
        int c;
        c = 1;
        while (expQ.size() > 0) begin
            @(negedge clk);
            e = expQ.pop_front();
            checkOutput($sformatf("%s_c%0d", name, c), e);
            c++;
        end
    endtask

    initial begin
        vecs[0] = '{SEQ_PATTERN_1001, 8'd1, 16'b1001,           4};
        vecs[1] = '{4'b1100,          8'd2, 16'b11001100,       8};
        vecs[2] = '{4'b0110,          8'd0, 16'b0,              0};
        vecs[3] = '{4'b1010,          8'd3, 16'b101010101010,  12};
        vecs[4] = '{4'b0111,          8'd1, 16'b0111,           4};
        vecs[5] = '{SEQ_PATTERN_1001, 8'd3, 16'b100110011001,  12};

        resetn      = 1'b1;
        start_valid = 1'b0;
        pattern     = '0;
        repeat_cnt  = '0;

        // Asynchronous reset between clock edges
        #2 resetn = 1'b0;
        #1 checkOutput("reset_async", 5'b00001);
        @(negedge clk);
        resetn = 1'b1;

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].pattern, vecs[i].rpt, 1'b0);
            buildExpected(vecs[i].bits, vecs[i].len, int'(vecs[i].rpt));
            expQ.push_back(5'b00001);
            playExpected($sformatf("vec%0d", i));
        end

        // repeat_cnt=0 with a second request held on start_valid through the done cycle
        applyStimulus(4'b0110, 8'd0, 1'b1);
        pattern    = SEQ_PATTERN_1001;
        repeat_cnt = 8'd1;
        buildExpected(16'b0, 0, 0);
        playExpected("zero_rpt");
        @(posedge clk);
        #1 start_valid = 1'b0;
        buildExpected(16'b1001, 4, 1);
        expQ.push_back(5'b00001);
        playExpected("b2b");

        // Inputs change and start_valid stays high while busy
        applyStimulus(SEQ_PATTERN_1001, 8'd2, 1'b1);
        pattern    = 4'b0110;
        repeat_cnt = 8'd1;
        buildExpected(16'b10011001, 8, 2);
        playExpected("ignore");
        @(posedge clk);
        #1 start_valid = 1'b0;
        buildExpected(16'b0110, 4, 1);
        expQ.push_back(5'b00001);
        playExpected("after_ignore");

        // Reset during bit 2 of repetition 2
        applyStimulus(SEQ_PATTERN_1001, 8'd3, 1'b0);
        buildExpected(16'b100110011001, 12, 3);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            checkOutput($sformatf("pre_reset_c%0d", c), expQ.pop_front());
        end
        expQ.delete();
        #1 resetn = 1'b0;
        #1 checkOutput("mid_reset", 5'b00001);
        @(negedge clk);
        resetn = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            checkOutput($sformatf("post_reset_c%0d", c), 5'b00001);
        end

        applyStimulus(4'b1100, 8'd1, 1'b0);
        buildExpected(16'b1100, 4, 1);
        expQ.push_back(5'b00001);
        playExpected("recover");

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/seq_generator.md
# seq_generator

Serial pattern transmitter: accepts a WIDTH-bit pattern and a repeat count over a valid/ready start handshake, then drives the pattern MSB-first on a single-bit output, one bit per clock, for the requested number of repetitions. It is the transmit end of the serial sequence-detection path: its `out` connects directly to the `in` of the sequence detector. It also serves as the stimulus source for detector-based FSM blocks.

## Interface
- `WIDTH`, 4: pattern length in bits; must be ≥ 2.
- `CNT_W`, 8: width of the repeat count.
- `clk`  in  1  clock; all state updates on the rising edge.
- `resetn`  in  1  reset; one clock, asynchronous, active-low.
- `start_valid`  in  1  request to start a transmission.
- `start_ready`  out  1  high when a request can be accepted (IDLE only).
- `pattern`  in  WIDTH  bits to send, sampled on accept; bit WIDTH-1 goes first.
- `repeat_cnt`  in  CNT_W  number of pattern repetitions, sampled on accept.
- `out`  out  1  serial data bit; 0 whenever `out_valid` is low.
- `out_valid`  out  1  high in every cycle that carries a pattern bit.
- `busy`  out  1  high from the cycle after accept until the last bit or gap cycle.
- `done`  out  1  single-cycle pulse marking completion of an accepted request.

## Operation
- States:
  - IDLE: start_ready=1.
  - SHIFT: driving bits.
  - GAP: only with the macro; see Configuration.
- Accept happens on a rising edge where `start_valid && start_ready`.
  - `pattern` is latched into a shift register; bit counter is set to WIDTH-1; repeat counter is set to `repeat_cnt`.
  - If `repeat_cnt`==0: FSM stays in IDLE and `done` pulses the next cycle. No bits are sent.
  - Otherwise: go to SHIFT.
- SHIFT behaviour:
  - Each cycle: out=shift-register MSB, out_valid=1, shift left by one, decrement bit counter.
  - When the bit counter reaches 0, decrement the repeat counter:
    - If it is now 0: go to IDLE and assert `done` for the following cycle.
    - Otherwise: reload the shift register from the latched pattern. Go to GAP if enabled, else stay in SHIFT.
- `pattern`, `repeat_cnt` and `start_valid` are ignored while not in IDLE. The latched copy is used for every repetition.
- All outputs are registered; no combinational input-to-output path.
- Reset values: out=0, out_valid=0, start_ready=1, busy=0, done=0, state=IDLE, counters=0.
- Reset mid-transmission: everything returns to the reset values immediately. No `done` is produced for the aborted request.

## Timing
- Accept on edge k → first bit valid in cycle k+1.
- WIDTH=4, R repeats, no gap: bits occupy cycles k+1 … k+4R; `done` is high in cycle k+4R+1.
- In the `done` cycle: start_ready=1 and busy=0. A new request may be accepted on that same edge, with its first bit in the next cycle (back-to-back requests, one-cycle bubble).
- `busy` equals the OR of SHIFT and GAP.
- With the gap enabled, each GAP cycle adds one cycle. The latency becomes WIDTH·R + (R−1) + 1.
- `repeat_cnt`==0: `done` is high in cycle k+1; start_ready stays 1 throughout.
- `repeat_cnt` maximum is 2^CNT_W−1. There is no wrap: the counter stops at 0.

## Configuration
- `SEQ_GENERATOR_GAP_EN` defined:
  - Between consecutive repetitions the FSM spends exactly one cycle in GAP, with out=0, out_valid=0, busy=1.
  - No gap before the first or after the last repetition.
- Undefined: GAP state is not compiled; repetitions are sent back-to-back with out_valid continuously high.

## Structure
- Shared package `seq_pkg` holds:
  - `seq_state_t` enum (IDLE, SHIFT, GAP), sized so all three states encode without overflow.
  - `SEQ_PATTERN_1001` = 4'b1001.
  - Default `WIDTH`/`CNT_W` constants.
- The FSM `case` has a default arm returning to IDLE.
- One sub-module: `seq_piso`, a parallel-in serial-out shift register with load/shift enables and MSB output. The FSM and counters stay in `seq_generator`.

## Test plan
- Reset asserted mid-cycle with no clock → all outputs at reset values. Release, then start with pattern=1001, repeat=1 → out = 1,0,0,1 in cycles k+1..k+4 with out_valid=1; done in k+5.
- Pattern=1001, repeat=3, generator `out` wired to the sequence detector `in` (no gap) → detector `out` high three times, in cycles k+4, k+8, k+12.
- Same stimulus with `SEQ_GENERATOR_GAP_EN` → out_valid low in cycles k+5 and k+10; done in k+15.
- repeat_cnt=0 → no out_valid; done in k+1. A second request held on `start_valid` is accepted on that edge and transmits normally.
- Change `pattern` to 0110 and hold `start_valid`=1 during a pattern=1001 transmission → output remains 1001 and no second accept occurs until `done`.
- Pull `resetn` low during bit 2 of repeat 2 → out_valid/busy drop immediately; no done pulse; start_ready=1 after release.
